uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer that sits between the RISC-V core's debug UART outputs (byte plus valid strobe) and the uart_tx serializer.
- Captures bytes written by the core, stores them in a circular FIFO, and drains them one at a time into uart_tx.
- Drain uses the serializer's DV/Active/Done handshake.
- Decouples the core, which runs from the divided slow clock, from the 104-clk-per-bit serial line, so back-to-back debug writes are not lost.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
ADDR_W, 4, log2(DEPTH).
WR_EDGE, 1, 1: write on rising edge of wr_valid through a 2-flop synchronizer; 0: write on every clk cycle wr_valid is high.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
wr_data  in  8  byte from core; must be stable while wr_valid is high.
wr_valid  in  1  write request (level from slow-clock domain when WR_EDGE=1).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  ADDR_W+1  current occupancy.
overflow  out  1  sticky; a write arrived while full.
tx_byte_o  out  8  to uart_tx i_Tx_Byte.
tx_dv_o  out  1  to uart_tx i_Tx_DV; single-cycle pulse.
tx_active_i  in  1  from uart_tx o_Tx_Active.
tx_done_i  in  1  from uart_tx o_Tx_Done.

Behaviour:
- Reset values (clk edge with reset=1):
  - wr_ptr=0, rd_ptr=0, count=0; empty=1, full=0, overflow=0.
  - tx_byte_o=8'h00, tx_dv_o=0, FSM=IDLE.
  - Synchronizer/edge flops cleared. Storage array is not reset.
- Write fire, WR_EDGE=1:
  - wr_fire = s2 & ~s3, where s1<=wr_valid, s2<=s1, s3<=s2.
  - wr_data is sampled in the wr_fire cycle, so the byte is stored 3 clk edges after wr_valid rises.
  - One write per rising edge, however long wr_valid is held.
- Write fire, WR_EDGE=0: wr_fire = wr_valid; data is stored on the same edge.
- Push: on wr_fire with full=0, mem[wr_ptr]<=wr_data and wr_ptr increments.
- Push while full: on wr_fire with full=1, the byte is dropped and overflow<=1. It stays 1 until reset.
- Pop: occurs only on the IDLE->START transition. tx_byte_o<=mem[rd_ptr] and rd_ptr increments.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- full/empty are registered from count, with no bypass:
  - A write in the same cycle as a pop while full is dropped, because full is evaluated before the pop.
  - A write to an empty FIFO becomes poppable on the next edge at the earliest.
- FSM states:
  - IDLE: go to START when empty=0 and tx_active_i=0; do the pop on this transition.
  - START: tx_dv_o=1 for exactly this one cycle; go to BUSY.
  - BUSY: tx_dv_o=0; stay until tx_done_i=1, then go to GAP.
  - GAP: one cycle so the serializer reaches idle; go to IDLE.
- tx_dv_o is high only in START, and is registered with the state.
- Minimum spacing between DV pulses is a full frame plus 3 cycles.
- tx_byte_o holds its value from pop until the next pop.
- Reset mid-frame: FIFO contents are discarded and the FSM returns to IDLE. uart_tx is not reset by this block and may finish its frame; the IDLE guard on tx_active_i=0 prevents a DV during that frame.
- tx_done_i outside BUSY is ignored.

Decomposition:
- Shared package: UART_BYTE_W=8; tx FSM state encoding IDLE=2'd0, START=2'd1, BUSY=2'd2, GAP=2'd3; default DEPTH.
- One natural sub-module, wr_edge_sync: the 2-flop synchronizer plus rising-edge detector producing wr_fire. Instantiated only when WR_EDGE=1.

Test Plan:
1. Reset, then WR_EDGE=1, wr_data=8'h41, wr_valid held high 200 cycles, with a uart_tx model (Active 1040 cycles, Done 1 cycle) -> exactly one push; count 0->1->0; one tx_dv_o pulse with tx_byte_o=8'h41; overflow=0.
2. Push 8'h00..8'h0F (16 bytes) with the serializer held active -> full=1, count=16. A 17th write (8'hAA) is dropped and overflow=1. Drained output order is 8'h00..8'h0F, with no 8'hAA.
3. Pointer wrap: 20 writes interleaved with drains, keeping the FIFO at most 10 deep -> output equals input order across the rd_ptr/wr_ptr 15->0 wrap.
4. Full FIFO, write fired in the same cycle as the IDLE->START pop -> write dropped, overflow=1, count=15 afterwards.
5. Assert reset during BUSY with 5 bytes queued and tx_active_i=1 -> next cycle count=0, empty=1, tx_dv_o=0. A write after reset produces no DV until tx_active_i falls.
6. WR_EDGE=0, wr_valid high 3 consecutive cycles with data 8'h10, 8'h11, 8'h12 -> count=3 after the third edge; output order 10, 11, 12; each DV pulse is exactly 1 cycle, with GAP ≥1 cycle after each tx_done_i.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and drain-FSM encoding for the debug UART transmit buffer.
package uart_tx_fifo_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2,
        TX_GAP   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_wr_edge_sync.sv
// Brings the slow-domain write level into clk and emits one fire pulse per rising edge.
module uart_tx_fifo_wr_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    output logic o_fire
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_valid;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_fire = r_s2 & ~r_s3;

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO between the core's debug writes and the uart_tx serializer.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int WR_EDGE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    output logic [UART_BYTE_W-1:0] tx_byte_o,
    output logic                   tx_dv_o,
    input  logic                   tx_active_i,
    input  logic                   tx_done_i
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_rd_ptr;
    logic [ADDR_W:0]        r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_overflow;
    logic [UART_BYTE_W-1:0] r_tx_byte;
    tx_state_t              r_state;

    tx_state_t              w_state_nxt;
    logic                   w_wr_fire;
    logic                   w_push;
    logic                   w_pop;
    logic [ADDR_W:0]        w_count_nxt;
    logic                   w_tx_dv;

    generate
        if (WR_EDGE != 0) begin : g_edge
            uart_tx_fifo_wr_edge_sync u_sync (
                .clk     (clk),
                .reset   (reset),
                .i_valid (wr_valid),
                .o_fire  (w_wr_fire)
            );
        end else begin : g_level
            assign w_wr_fire = wr_valid;
        end
    endgenerate

    // full/empty are the registered view, so a write racing a pop on a full FIFO is dropped
    assign w_push      = w_wr_fire & ~r_full;
    assign w_pop       = (r_state == TX_IDLE) & (w_state_nxt == TX_START);
    assign w_count_nxt = r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_wr_fire && r_full)
                r_overflow <= 1'b1;
            if (w_pop) begin
                r_tx_byte <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= TX_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Gating on tx_active_i keeps us from strobing DV into a frame left over from before reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE:  if (!r_empty && !tx_active_i) w_state_nxt = TX_START;
            TX_START: w_state_nxt = TX_BUSY;
            TX_BUSY:  if (tx_done_i) w_state_nxt = TX_GAP;
            TX_GAP:   w_state_nxt = TX_IDLE;
            default:  w_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_dv = (r_state == TX_START);
    end

    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign tx_byte_o = r_tx_byte;
    assign tx_dv_o   = w_tx_dv;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed scoreboard bench: edge-mode instance for the held-write case, level-mode instance for the rest.
module tb_uart_tx_fifo;

    localparam int FRAME_E = 1040;
    localparam int FRAME_L = 20;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // edge-mode DUT
    logic       rst_e, wv_e, act_m_e, done_e;
    logic [7:0] wd_e, byte_e;
    logic       full_e, empty_e, ovf_e, dv_e;
    logic [4:0] cnt_e;

    // level-mode DUT
    logic       rst_l, wv_l, act_m_l, done_l, force_l;
    logic [7:0] wd_l, byte_l;
    logic       full_l, empty_l, ovf_l, dv_l;
    logic [4:0] cnt_l;
    logic       act_l;
    assign act_l = act_m_l | force_l;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .WR_EDGE(1)) dut_e (
        .clk(clk), .reset(rst_e), .wr_data(wd_e), .wr_valid(wv_e),
        .full(full_e), .empty(empty_e), .count(cnt_e), .overflow(ovf_e),
        .tx_byte_o(byte_e), .tx_dv_o(dv_e), .tx_active_i(act_m_e), .tx_done_i(done_e)
    );

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .WR_EDGE(0)) dut_l (
        .clk(clk), .reset(rst_l), .wr_data(wd_l), .wr_valid(wv_l),
        .full(full_l), .empty(empty_l), .count(cnt_l), .overflow(ovf_l),
        .tx_byte_o(byte_l), .tx_dv_o(dv_l), .tx_active_i(act_l), .tx_done_i(done_l)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sbq_l [$];
    int dv_cnt_e = 0;
    int dv_cnt_l = 0;
    int cyc_l = 0;
    int last_done_l = -100;
    logic prev_dv_l = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Serializer models: one frame of Active after each DV, then a 1-cycle Done
    initial begin
        act_m_e = 1'b0; done_e = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dv_e) begin
                act_m_e = 1'b1;
                repeat (FRAME_E) @(posedge clk);
                #1 act_m_e = 1'b0; done_e = 1'b1;
                @(posedge clk);
                #1 done_e = 1'b0;
            end
        end
    end

    initial begin
        act_m_l = 1'b0; done_l = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dv_l) begin
                act_m_l = 1'b1;
                repeat (FRAME_L) @(posedge clk);
                #1 act_m_l = 1'b0; done_l = 1'b1;
                @(posedge clk);
                #1 done_l = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_e && dv_e) begin
            dv_cnt_e++;
            check("e_tx_byte", byte_e, 8'h41);
        end
    end

    // Level-DUT monitor: DV width, GAP spacing after Done, and byte order
    always @(negedge clk) begin
        if (!rst_l) begin
            cyc_l++;
            if (done_l) last_done_l = cyc_l;
            if (dv_l) begin
                dv_cnt_l++;
                check("dv_width", prev_dv_l, 1'b0);
                check("dv_gap", (cyc_l - last_done_l) >= 3, 1'b1);
                if (sbq_l.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_dv: got byte %0h, expected no DV", byte_l);
                end else begin
                    check("tx_byte", byte_l, sbq_l.pop_front());
                end
            end
        end
        prev_dv_l = dv_l;
    end

    task automatic wr_l(input logic [7:0] b, input bit exp);
        wd_l = b;
        wv_l = 1'b1;
        if (exp) sbq_l.push_back(b);
        @(negedge clk);
        wv_l = 1'b0;
    endtask

    task automatic reset_l();
        rst_l = 1'b1;
        @(negedge clk);
        rst_l = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sbq_l.size() != 0 || cnt_l != 0 || act_m_l) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    initial begin
        rst_e = 1'b1; rst_l = 1'b1; wv_e = 1'b0; wv_l = 1'b0;
        wd_e = 8'h00; wd_l = 8'h00; force_l = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", cnt_l, 0);
        check("rst_empty", empty_l, 1);
        check("rst_full", full_l, 0);
        check("rst_ovf", ovf_l, 0);
        check("rst_dv", dv_l, 0);
        check("rst_byte", byte_l, 8'h00);
        check("rst_e_empty", empty_e, 1);
        rst_e = 1'b0; rst_l = 1'b0;

        // 1: edge mode, level held 200 cycles -> one push, one DV
        wd_e = 8'h41; wv_e = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_count_pre", cnt_e, 0);
        @(negedge clk);
        check("t1_count_push", cnt_e, 1);
        @(negedge clk);
        check("t1_count_pop", cnt_e, 0);
        check("t1_dv", dv_e, 1);
        repeat (196) @(negedge clk);
        wv_e = 1'b0;
        repeat (1000) @(negedge clk);
        check("t1_dv_cnt", dv_cnt_e, 1);
        check("t1_count_end", cnt_e, 0);
        check("t1_ovf", ovf_e, 0);

        // 6: level mode, three back-to-back writes
        force_l = 1'b1;
        wr_l(8'h10, 1); wr_l(8'h11, 1); wr_l(8'h12, 1);
        check("t6_count", cnt_l, 3);
        force_l = 1'b0;
        wait_drain("t6_drain", 500);

        // 2: fill to 16, 17th dropped
        force_l = 1'b1;
        for (int i = 0; i < 16; i++) wr_l(8'(i), 1);
        check("t2_count", cnt_l, 16);
        check("t2_full", full_l, 1);
        check("t2_ovf_pre", ovf_l, 0);
        wr_l(8'hAA, 0);
        check("t2_ovf", ovf_l, 1);
        check("t2_count_after", cnt_l, 16);
        force_l = 1'b0;
        wait_drain("t2_drain", 1000);

        // 3: 20 writes in groups of 5 across the pointer wrap
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 5; i++) wr_l(8'h20 + 8'(g * 5 + i), 1);
            check("t3_depth", cnt_l <= 10, 1'b1);
            wait_drain("t3_drain", 500);
        end

        // 4: write on the same edge as the pop of a full FIFO
        reset_l();
        check("t4_ovf_clr", ovf_l, 0);
        force_l = 1'b1;
        for (int i = 0; i < 16; i++) wr_l(8'h30 + 8'(i), 1);
        check("t4_full", full_l, 1);
        force_l = 1'b0;
        wr_l(8'hBB, 0);
        check("t4_count", cnt_l, 15);
        check("t4_ovf", ovf_l, 1);
        wait_drain("t4_drain", 1000);

        // 5: reset during BUSY with 5 queued, serializer still active
        for (int i = 0; i < 6; i++) wr_l(8'h50 + 8'(i), 1);
        force_l = 1'b1;
        check("t5_count_pre", cnt_l, 5);
        repeat (3) @(negedge clk);
        reset_l();
        sbq_l.delete();
        check("t5_count", cnt_l, 0);
        check("t5_empty", empty_l, 1);
        check("t5_dv", dv_l, 0);
        begin
            int dv0;
            dv0 = dv_cnt_l;
            wr_l(8'h77, 1);
            repeat (40) @(negedge clk);
            check("t5_no_dv", dv_cnt_l, dv0);
            check("t5_held", cnt_l, 1);
        end
        force_l = 1'b0;
        wait_drain("t5_drain", 500);
        check("sb_empty", sbq_l.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1);
    end

endmodule
